mc14500_sequencer: RTL and testbench

Instruction sequencer for the MC14500B core. It sits between the program counter, the synchronous program memory and the logic unit. Each cycle it decodes the fetched instruction word and drives the counter's load port for JMP and RTN. It squashes the in-flight instruction after a taken branch or SKZ, and keeps a small return-address stack so JMP/RTN behave as call/return.

---
 rtl/mc14500_pkg.sv | 33 +++
 rtl/mc14500_return_stack.sv | 51 +++++
 rtl/mc14500_sequencer.sv | 125 ++++++++++++
 tb/tb_mc14500_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc14500_pkg.sv
// Shared definitions for the MC14500B sequencer: opcode encoding, instruction
// field positions and the execute-slot state.
package mc14500_pkg;

  typedef enum logic [3:0] {
    OP_NOPO = 4'h0,
    OP_LD   = 4'h1,
    OP_LDC  = 4'h2,
    OP_AND  = 4'h3,
    OP_ANDC = 4'h4,
    OP_OR   = 4'h5,
    OP_ORC  = 4'h6,
    OP_XNOR = 4'h7,
    OP_STO  = 4'h8,
    OP_STOC = 4'h9,
    OP_IEN  = 4'hA,
    OP_OEN  = 4'hB,
    OP_JMP  = 4'hC,
    OP_RTN  = 4'hD,
    OP_SKZ  = 4'hE,
    OP_NOPF = 4'hF
  } opcode_e;

  localparam int OPC_LSB   = 0;
  localparam int OPC_MSB   = 3;
  localparam int OPC_WIDTH = OPC_MSB - OPC_LSB + 1;

  typedef enum logic {
    SLOT_LIVE = 1'b0,
    SLOT_KILL = 1'b1
  } slot_e;

endpackage

// File: rtl/mc14500_return_stack.sv
// Circular return-address stack. A push when full overwrites the oldest entry;
// overflow/underflow reporting is left to the sequencer.
module mc14500_return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [PTR_W-1:0] next_ptr;
  logic [CNT_W-1:0] count;

  // wr_ptr always names the slot the next push lands in; the top is one behind it
  assign top_ptr  = (wr_ptr == '0) ? PTR_W'(DEPTH - 1) : wr_ptr - PTR_W'(1);
  assign next_ptr = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);

  assign dout  = mem[top_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (push) begin
      wr_ptr <= next_ptr;
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr <= top_ptr;
      count  <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/mc14500_sequencer.sv
// Execute-stage sequencer for the MC14500B: decodes the fetched word, drives
// counter loads for JMP/RTN, squashes the slot after a taken branch or SKZ.
module mc14500_sequencer
  import mc14500_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH+3:0] imem_data,
  input  logic                  rr,
  output logic                  pc_write,
  output logic [ADDR_WIDTH-1:0] pc_addr,
  output logic                  exec_valid,
  output logic [3:0]            exec_opcode,
  output logic [ADDR_WIDTH-1:0] exec_operand,
  output logic                  flag_o,
  output logic                  flag_f,
  output logic                  jmp,
  output logic                  rtn,
  output logic                  stack_err
);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] operand;
    opcode_e               opcode;
  } instr_t;

  instr_t                instr;
  slot_e                 slot_q;
  slot_e                 slot_d;
  logic                  live;
  logic                  push;
  logic                  pop;
  logic                  err_set;
  logic                  err_q;
  logic                  stk_empty;
  logic                  stk_full;
  logic [ADDR_WIDTH-1:0] stk_dout;

  assign instr = imem_data;
  // Reset overrides a squash-free slot so nothing leaks out while it is held
  assign live  = (slot_q == SLOT_LIVE) && !reset;

  always_ff @(posedge clk) begin
    if (reset) slot_q <= SLOT_KILL;
    else       slot_q <= slot_d;
  end

  always_comb begin
    slot_d = SLOT_LIVE;
    if (live) begin
      case (instr.opcode)
        OP_JMP:  slot_d = SLOT_KILL;
        OP_RTN:  if (!stk_empty) slot_d = SLOT_KILL;
        OP_SKZ:  if (!rr) slot_d = SLOT_KILL;
        default: slot_d = SLOT_LIVE;
      endcase
    end
  end

  always_comb begin
    pc_write     = 1'b0;
    pc_addr      = '0;
    flag_o       = 1'b0;
    flag_f       = 1'b0;
    jmp          = 1'b0;
    rtn          = 1'b0;
    push         = 1'b0;
    pop          = 1'b0;
    err_set      = 1'b0;
    exec_valid   = live;
    exec_opcode  = reset ? '0 : imem_data[OPC_MSB:OPC_LSB];
    exec_operand = reset ? '0 : instr.operand;
    if (live) begin
      case (instr.opcode)
        OP_NOPO: flag_o = 1'b1;
        OP_NOPF: flag_f = 1'b1;
        OP_JMP: begin
          push     = 1'b1;
          pc_write = 1'b1;
          pc_addr  = instr.operand;
          jmp      = 1'b1;
          err_set  = stk_full;
        end
        OP_RTN: begin
          if (!stk_empty) begin
            pop      = 1'b1;
            pc_write = 1'b1;
            pc_addr  = stk_dout;
            rtn      = 1'b1;
          end else begin
            err_set  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        err_q <= 1'b0;
    else if (err_set) err_q <= 1'b1;
  end

  assign stack_err = err_q && !reset;

  // pc already points past the JMP, so it is exactly the return address
  mc14500_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (pc),
    .dout  (stk_dout),
    .empty (stk_empty),
    .full  (stk_full)
  );

endmodule

// File: tb/tb_mc14500_sequencer.sv
// Directed bench for mc14500_sequencer with a behavioural program counter and
// synchronous program memory around it.
module tb_mc14500_sequencer;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cnt_reset;
  logic [AW-1:0] pc;
  logic [AW+3:0] imem_data;
  logic          rr;
  logic          pc_write;
  logic [AW-1:0] pc_addr;
  logic          exec_valid;
  logic [3:0]    exec_opcode;
  logic [AW-1:0] exec_operand;
  logic          flag_o;
  logic          flag_f;
  logic          jmp;
  logic          rtn;
  logic          stack_err;

  logic [AW+3:0] mem [256];
  int            checks   = 0;
  int            failures = 0;

  typedef struct {
    logic       valid;
    logic [3:0] opc;
    logic [7:0] operand;
    logic       pcw;
    logic [7:0] addr;
    logic       fo;
    logic       ff;
    logic       j;
    logic       r;
    logic       err;
    logic       rrv;
  } slot_t;

  slot_t slots[$];

  mc14500_sequencer #(
    .ADDR_WIDTH  (AW),
    .STACK_DEPTH (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .imem_data    (imem_data),
    .rr           (rr),
    .pc_write     (pc_write),
    .pc_addr      (pc_addr),
    .exec_valid   (exec_valid),
    .exec_opcode  (exec_opcode),
    .exec_operand (exec_operand),
    .flag_o       (flag_o),
    .flag_f       (flag_f),
    .jmp          (jmp),
    .rtn          (rtn),
    .stack_err    (stack_err)
  );

  always #5 clk = ~clk;

  // Counter leaves reset one edge before the sequencer so M[0] is fetched
  // while the all-ones slot is being squashed
  always @(posedge clk) begin
    if (cnt_reset)     pc <= '1;
    else if (pc_write) pc <= pc_addr;
    else               pc <= pc + 8'd1;
    imem_data <= mem[pc];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic addSlot(input logic v, input logic [3:0] o, input logic [7:0] opnd,
                         input logic pcw, input logic [7:0] a, input logic fo, input logic ff,
                         input logic j, input logic r, input logic err, input logic rrv);
    slot_t s;
    s.valid = v; s.opc = o; s.operand = opnd; s.pcw = pcw; s.addr = a;
    s.fo = fo; s.ff = ff; s.j = j; s.r = r; s.err = err; s.rrv = rrv;
    slots.push_back(s);
  endtask

  function automatic logic [AW+3:0] word(input logic [3:0] o, input logic [7:0] a);
    return {a, o};
  endfunction

  task automatic applyStimulus(input logic rrv);
    rr = rrv;
    #1;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, " valid"}, 32'(exec_valid), 32'd0);
    checkOutput({tag, " pc_write"}, 32'(pc_write), 32'd0);
    checkOutput({tag, " jmp"}, 32'(jmp), 32'd0);
    checkOutput({tag, " rtn"}, 32'(rtn), 32'd0);
    checkOutput({tag, " opcode"}, 32'(exec_opcode), 32'd0);
    checkOutput({tag, " stack_err"}, 32'(stack_err), 32'd0);
  endtask

  task automatic applyReset(input string tag);
    reset = 1'b1;
    cnt_reset = 1'b1;
    rr = 1'b1;
    #1;
    checkReset(tag);
    repeat (2) @(posedge clk);
    #1;
    cnt_reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic runSlots(input int first, input int last, input string pass);
    for (int i = first; i <= last; i++) begin
      applyStimulus(slots[i].rrv);
      checkOutput($sformatf("%s c%0d valid", pass, i + 1), 32'(exec_valid), 32'(slots[i].valid));
      checkOutput($sformatf("%s c%0d pc_write", pass, i + 1), 32'(pc_write), 32'(slots[i].pcw));
      checkOutput($sformatf("%s c%0d flag_o", pass, i + 1), 32'(flag_o), 32'(slots[i].fo));
      checkOutput($sformatf("%s c%0d flag_f", pass, i + 1), 32'(flag_f), 32'(slots[i].ff));
      checkOutput($sformatf("%s c%0d jmp", pass, i + 1), 32'(jmp), 32'(slots[i].j));
      checkOutput($sformatf("%s c%0d rtn", pass, i + 1), 32'(rtn), 32'(slots[i].r));
      checkOutput($sformatf("%s c%0d stack_err", pass, i + 1), 32'(stack_err), 32'(slots[i].err));
      if (slots[i].pcw)
        checkOutput($sformatf("%s c%0d pc_addr", pass, i + 1), 32'(pc_addr), 32'(slots[i].addr));
      if (slots[i].valid) begin
        checkOutput($sformatf("%s c%0d opcode", pass, i + 1), 32'(exec_opcode), 32'(slots[i].opc));
        checkOutput($sformatf("%s c%0d operand", pass, i + 1), 32'(exec_operand), 32'(slots[i].operand));
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1;
    cnt_reset = 1'b1;
    rr = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[8'h00] = word(4'h1, 8'h01);
    mem[8'h01] = word(4'h3, 8'h02);
    mem[8'h02] = word(4'h8, 8'h03);
    mem[8'h03] = word(4'h0, 8'h00);
    mem[8'h04] = word(4'h1, 8'h04);
    mem[8'h05] = word(4'hC, 8'h20);
    mem[8'h06] = word(4'h5, 8'h05);
    mem[8'h07] = word(4'h1, 8'h06);
    mem[8'h08] = word(4'hE, 8'h00);
    mem[8'h09] = word(4'hC, 8'h40);
    mem[8'h0A] = word(4'hE, 8'h00);
    mem[8'h0B] = word(4'h2, 8'h07);
    mem[8'h0C] = word(4'hC, 8'h30);
    mem[8'h0D] = word(4'hF, 8'h00);
    mem[8'h20] = word(4'h1, 8'h08);
    mem[8'h21] = word(4'h7, 8'h09);
    mem[8'h22] = word(4'hD, 8'h00);
    mem[8'h23] = word(4'h6, 8'h0A);
    mem[8'h30] = word(4'hC, 8'h40);
    mem[8'h31] = word(4'hD, 8'h00);
    mem[8'h32] = word(4'hF, 8'h00);
    mem[8'h33] = word(4'hC, 8'h80);
    mem[8'h40] = word(4'hC, 8'h50);
    mem[8'h41] = word(4'hD, 8'h00);
    mem[8'h50] = word(4'hC, 8'h60);
    mem[8'h51] = word(4'hD, 8'h00);
    mem[8'h60] = word(4'hC, 8'h70);
    mem[8'h61] = word(4'hD, 8'h00);
    mem[8'h70] = word(4'hD, 8'h00);
    mem[8'h71] = word(4'hA, 8'h0C);
    mem[8'hFF] = word(4'hB, 8'h0B);

    //      v  opc    opnd   pcw addr   fo ff j  r  err rr
    addSlot(0, 4'hB, 8'h0B, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'h1, 8'h01, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'h3, 8'h02, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'h8, 8'h03, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'h0, 8'h00, 0, 8'h00, 1, 0, 0, 0, 0, 1);
    addSlot(1, 4'h1, 8'h04, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'hC, 8'h20, 1, 8'h20, 0, 0, 1, 0, 0, 1);
    addSlot(0, 4'h5, 8'h05, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'h1, 8'h08, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'h7, 8'h09, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'hD, 8'h00, 1, 8'h06, 0, 0, 0, 1, 0, 1);
    addSlot(0, 4'h6, 8'h0A, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'h5, 8'h05, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'h1, 8'h06, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'hE, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0);
    addSlot(0, 4'hC, 8'h40, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'hE, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'h2, 8'h07, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'hC, 8'h30, 1, 8'h30, 0, 0, 1, 0, 0, 1);
    addSlot(0, 4'hF, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'hC, 8'h40, 1, 8'h40, 0, 0, 1, 0, 0, 1);
    addSlot(0, 4'hD, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'hC, 8'h50, 1, 8'h50, 0, 0, 1, 0, 0, 1);
    addSlot(0, 4'hD, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'hC, 8'h60, 1, 8'h60, 0, 0, 1, 0, 0, 1);
    addSlot(0, 4'hD, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 1);
    addSlot(1, 4'hC, 8'h70, 1, 8'h70, 0, 0, 1, 0, 0, 1);
    addSlot(0, 4'hD, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1);
    addSlot(1, 4'hD, 8'h00, 1, 8'h61, 0, 0, 0, 1, 1, 1);
    addSlot(0, 4'hA, 8'h0C, 0, 8'h00, 0, 0, 0, 0, 1, 1);
    addSlot(1, 4'hD, 8'h00, 1, 8'h51, 0, 0, 0, 1, 1, 1);
    addSlot(0, 4'h0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1);
    addSlot(1, 4'hD, 8'h00, 1, 8'h41, 0, 0, 0, 1, 1, 1);
    addSlot(0, 4'h0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1);
    addSlot(1, 4'hD, 8'h00, 1, 8'h31, 0, 0, 0, 1, 1, 1);
    addSlot(0, 4'h0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1);
    addSlot(1, 4'hD, 8'h00, 0, 8'h00, 0, 0, 0, 0, 1, 1);
    addSlot(1, 4'hF, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 1);

    $display("[TB] power-on reset");
    applyReset("rst0");
    runSlots(0, slots.size() - 1, "run");

    $display("[TB] reset during JMP at 0x33");
    checkOutput("pre-rst jmp", 32'(jmp), 32'd1);
    applyReset("rst1");
    runSlots(0, 12, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
